alu181_nibble_sequencer: RTL and testbench

Multi-cycle controller that runs a WIDTH-bit arithmetic/logic operation through one shared 4-bit 74x181-style ALU slice, one nibble per clock, least significant nibble first. It latches a request, drives the slice's A/B/S/M/ci_bar inputs each cycle, and ripples the active-low carry between nibbles through a register. It collects F, carry-out and A=B into a registered response. It sits between a requester (valid/ready) and a single combinational 74x181 slice instantiated outside this block.

---
 rtl/alu181_nibble_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_alu181_nibble_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu181_nibble_sequencer.sv
// Nibble-serial sequencer that drives one external 74x181-style 4-bit ALU slice,
// rippling the active-low carry between nibbles and assembling a WIDTH-bit response.
module alu181_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_ci_bar,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_ci_bar,
  input  logic [3:0]       alu_f,
  input  logic             alu_co_bar,
  input  logic             alu_a_eq_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_co_bar,
  output logic             rsp_a_eq_b
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [WIDTH-1:0]   a_r, a_s;
  logic [WIDTH-1:0]   b_r, b_s;
  logic               eq_r, eq_s;
  logic               req_ready_r, req_ready_s;
  logic               rsp_valid_r, rsp_valid_s;
  logic [WIDTH-1:0]   rsp_f_r, rsp_f_s;
  logic               rsp_co_bar_r, rsp_co_bar_s;
  logic               rsp_a_eq_b_r, rsp_a_eq_b_s;
  logic [3:0]         alu_a_r, alu_a_s;
  logic [3:0]         alu_b_r, alu_b_s;
  logic [3:0]         alu_s_r, alu_s_s;
  logic               alu_m_r, alu_m_s;
  // alu_ci_bar_r doubles as the inter-nibble carry register.
  logic               alu_ci_bar_r, alu_ci_bar_s;

  function automatic logic [3:0] nibble_of(input logic [WIDTH-1:0] v,
                                           input logic [CNT_W-1:0] idx);
    logic [3:0] n;
    n = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == CNT_W'(i)) begin
        n = v[4*i +: 4];
      end
    end
    return n;
  endfunction

  // Next-state, datapath and next-output decode for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    a_s          = a_r;
    b_s          = b_r;
    eq_s         = eq_r;
    rsp_f_s      = rsp_f_r;
    rsp_co_bar_s = rsp_co_bar_r;
    rsp_a_eq_b_s = rsp_a_eq_b_r;
    alu_a_s      = 4'h0;
    alu_b_s      = 4'h0;
    alu_s_s      = 4'h0;
    alu_m_s      = 1'b0;
    alu_ci_bar_s = 1'b1;

    case (state_r)
      IDLE: begin
        if (req_valid) begin
          a_s          = req_a;
          b_s          = req_b;
          cnt_s        = CNT_W'(0);
          eq_s         = 1'b1;
          alu_a_s      = req_a[3:0];
          alu_b_s      = req_b[3:0];
          alu_s_s      = req_s;
          alu_m_s      = req_m;
          alu_ci_bar_s = req_ci_bar;
          state_s      = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (cnt_r == CNT_W'(i)) begin
            rsp_f_s[4*i +: 4] = alu_f;
          end else begin
            rsp_f_s[4*i +: 4] = rsp_f_r[4*i +: 4];
          end
        end
        eq_s = eq_r & alu_a_eq_b;
        if (cnt_r == LAST_CNT) begin
          rsp_co_bar_s = alu_co_bar;
          rsp_a_eq_b_s = eq_r & alu_a_eq_b;
          cnt_s        = CNT_W'(0);
          state_s      = DONE;
        end else begin
          cnt_s        = cnt_r + CNT_W'(1);
          alu_a_s      = nibble_of(a_r, cnt_r + CNT_W'(1));
          alu_b_s      = nibble_of(b_r, cnt_r + CNT_W'(1));
          alu_s_s      = alu_s_r;
          alu_m_s      = alu_m_r;
          alu_ci_bar_s = alu_co_bar;
          state_s      = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    req_ready_s = (state_s == IDLE);
    rsp_valid_s = (state_s == DONE);
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, nibble counter, response and slice-drive registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= CNT_W'(0);
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      eq_r         <= 1'b1;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_f_r      <= {WIDTH{1'b0}};
      rsp_co_bar_r <= 1'b1;
      rsp_a_eq_b_r <= 1'b0;
      alu_a_r      <= 4'h0;
      alu_b_r      <= 4'h0;
      alu_s_r      <= 4'h0;
      alu_m_r      <= 1'b0;
      alu_ci_bar_r <= 1'b1;
    end else begin
      cnt_r        <= cnt_s;
      a_r          <= a_s;
      b_r          <= b_s;
      eq_r         <= eq_s;
      req_ready_r  <= req_ready_s;
      rsp_valid_r  <= rsp_valid_s;
      rsp_f_r      <= rsp_f_s;
      rsp_co_bar_r <= rsp_co_bar_s;
      rsp_a_eq_b_r <= rsp_a_eq_b_s;
      alu_a_r      <= alu_a_s;
      alu_b_r      <= alu_b_s;
      alu_s_r      <= alu_s_s;
      alu_m_r      <= alu_m_s;
      alu_ci_bar_r <= alu_ci_bar_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_f      = rsp_f_r;
  assign rsp_co_bar = rsp_co_bar_r;
  assign rsp_a_eq_b = rsp_a_eq_b_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_s      = alu_s_r;
  assign alu_m      = alu_m_r;
  assign alu_ci_bar = alu_ci_bar_r;

endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// Directed bench for alu181_nibble_sequencer with a behavioural 74x181 slice
// attached to the alu_* ports.
module tb_alu181_nibble_sequencer;

  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [WIDTH-1:0]  req_a;
  logic [WIDTH-1:0]  req_b;
  logic [3:0]        req_s;
  logic              req_m;
  logic              req_ci_bar;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [3:0]        alu_s;
  logic              alu_m;
  logic              alu_ci_bar;
  logic [3:0]        alu_f;
  logic              alu_co_bar;
  logic              alu_a_eq_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_f;
  logic              rsp_co_bar;
  logic              rsp_a_eq_b;

  int checks   = 0;
  int failures = 0;

  logic [3:0] term_a;
  logic [3:0] term_b;
  logic [4:0] sum;

  alu181_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_s      (req_s),
    .req_m      (req_m),
    .req_ci_bar (req_ci_bar),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_m      (alu_m),
    .alu_ci_bar (alu_ci_bar),
    .alu_f      (alu_f),
    .alu_co_bar (alu_co_bar),
    .alu_a_eq_b (alu_a_eq_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_f      (rsp_f),
    .rsp_co_bar (rsp_co_bar),
    .rsp_a_eq_b (rsp_a_eq_b)
  );

  always #5 clk = ~clk;

  // 74x181 slice, active-high data: arithmetic F = (A | B.S0 | ~B.S1) + (A.~B.S2 | A.B.S3) + Cn
  always_comb begin
    term_a     = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    term_b     = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    sum        = {1'b0, term_a} + {1'b0, term_b} + {4'b0000, ~alu_ci_bar};
    alu_f      = alu_m ? ~(term_a ^ term_b) : sum[3:0];
    alu_co_bar = ~sum[4];
    alu_a_eq_b = (alu_f == 4'hF);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [3:0] s, input logic m, input logic ci);
    req_a      = a;
    req_b      = b;
    req_s      = s;
    req_m      = m;
    req_ci_bar = ci;
    req_valid  = 1'b1;
    step();
    chk("accept_ready_low", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("ack_req_ready", 32'(req_ready), 32'd1);
    chk("ack_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = 16'h0000;
    req_b      = 16'h0000;
    req_s      = 4'h0;
    req_m      = 1'b0;
    req_ci_bar = 1'b1;
    rsp_ready  = 1'b0;
    step();
    step();
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_rsp_f",      32'(rsp_f),      32'h0);
    chk("rst_rsp_co_bar", 32'(rsp_co_bar), 32'd1);
    chk("rst_rsp_eq",     32'(rsp_a_eq_b), 32'd0);
    chk("rst_alu_ci_bar", 32'(alu_ci_bar), 32'd1);
    chk("rst_alu_a",      32'(alu_a),      32'h0);
    rst_n = 1'b1;
    step();

    // Add 0x00FF + 0x0001, exact latency of four edges after acceptance
    issue(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    chk("add_alu_a_n0", 32'(alu_a), 32'hF);
    chk("add_alu_b_n0", 32'(alu_b), 32'h1);
    chk("add_alu_s",    32'(alu_s), 32'h9);
    step(); step(); step();
    chk("add_valid_early", 32'(rsp_valid), 32'd0);
    step();
    chk("add_valid_lat4", 32'(rsp_valid),  32'd1);
    chk("add_f",          32'(rsp_f),      32'h0100);
    chk("add_co_bar",     32'(rsp_co_bar), 32'd1);
    chk("add_idle_ci",    32'(alu_ci_bar), 32'd1);
    ack();

    // Add overflow: carry ripples into every upper nibble
    issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    chk("ovf_ci_n0", 32'(alu_ci_bar), 32'd1);
    step();
    chk("ovf_ci_n1", 32'(alu_ci_bar), 32'd0);
    step();
    chk("ovf_ci_n2", 32'(alu_ci_bar), 32'd0);
    step();
    chk("ovf_ci_n3", 32'(alu_ci_bar), 32'd0);
    step();
    chk("ovf_valid",  32'(rsp_valid),  32'd1);
    chk("ovf_f",      32'(rsp_f),      32'h0000);
    chk("ovf_co_bar", 32'(rsp_co_bar), 32'd0);
    ack();

    // Compare: A minus B minus 1 gives all ones when equal
    issue(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1);
    wait_rsp();
    chk("cmp_eq_f",  32'(rsp_f),      32'hFFFF);
    chk("cmp_eq_eq", 32'(rsp_a_eq_b), 32'd1);
    chk("cmp_eq_co", 32'(rsp_co_bar), 32'd1);
    ack();
    issue(16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b1);
    wait_rsp();
    chk("cmp_ne_f",  32'(rsp_f),      32'hFFFE);
    chk("cmp_ne_eq", 32'(rsp_a_eq_b), 32'd0);
    ack();

    // Logic XOR with the response held for five cycles and a stray request
    issue(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);
    chk("xor_alu_m", 32'(alu_m), 32'd1);
    wait_rsp();
    chk("xor_f", 32'(rsp_f), 32'h0FF0);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_f",     32'(rsp_f),     32'h0FF0);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    ack();

    // Asynchronous reset while nibble 2 is in flight
    issue(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(rsp_valid),  32'd0);
    chk("mid_rst_f",      32'(rsp_f),      32'h0);
    chk("mid_rst_co_bar", 32'(rsp_co_bar), 32'd1);
    chk("mid_rst_ready",  32'(req_ready),  32'd1);
    chk("mid_rst_alu_a",  32'(alu_a),      32'h0);
    chk("mid_rst_alu_ci", 32'(alu_ci_bar), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    issue(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1);
    wait_rsp();
    chk("post_rst_f",  32'(rsp_f),      32'h2345);
    chk("post_rst_co", 32'(rsp_co_bar), 32'd1);
    ack();

    // Back-to-back with req_valid and rsp_ready held; operands change during RUN
    req_a      = 16'h0001;
    req_b      = 16'h0001;
    req_s      = 4'b1001;
    req_m      = 1'b0;
    req_ci_bar = 1'b1;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    step();
    chk("b2b_accept1", 32'(req_ready), 32'd0);
    req_a = 16'h0003;
    req_b = 16'h0004;
    step(); step(); step();
    chk("b2b_run_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("b2b_done1_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_done1_f",     32'(rsp_f),     32'h0002);
    step();
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    chk("b2b_idle_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("b2b_accept2", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    step(); step(); step(); step();
    chk("b2b_done2_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_done2_f",     32'(rsp_f),     32'h0007);
    step();
    rsp_ready = 1'b0;
    chk("b2b_final_ready", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
